// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter of the multicycle MIPS core.
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} arb_state_t;
  typedef enum logic {OWN_FETCH, OWN_DATA} arb_owner_t;

  localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/mem_arb_grant.sv
// Combinational winner select between fetch and data requests.
// Macro MEM_ARB_ROUND_ROBIN_EN: alternate on ties; otherwise data has fixed priority.
module mem_arb_grant
  import mem_arb_pkg::*;
(
  input  logic       if_req,
  input  logic       d_req,
  input  arb_owner_t last_owner,
  output arb_owner_t grant
);

  always_comb begin
    // NOTE: assign a default before any branch so no path leaves grant unassigned (no latch).
    grant = last_owner;
    if (if_req && d_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      grant = (last_owner == OWN_FETCH) ? OWN_DATA : OWN_FETCH;
`else
      grant = OWN_DATA;
`endif
    end else if (d_req) begin
      grant = OWN_DATA;
    end else if (if_req) begin
      grant = OWN_FETCH;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Sequences one shared memory between instruction fetch and data access with wait states.
// Macro MEM_ARB_ROUND_ROBIN_EN selects round-robin tie-breaking in mem_arb_grant.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int BIT_WIDTH   = 32,
  parameter int WAIT_STATES = 1,
  parameter int ADDR_SHIFT  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 if_req_in,
  input  logic [BIT_WIDTH-1:0] if_addr_in,
  output logic [BIT_WIDTH-1:0] if_rdata_out,
  output logic                 if_ack_out,
  input  logic                 d_req_in,
  input  logic                 d_we_in,
  input  logic [BIT_WIDTH-1:0] d_addr_in,
  input  logic [BIT_WIDTH-1:0] d_wdata_in,
  output logic [BIT_WIDTH-1:0] d_rdata_out,
  output logic                 d_ack_out,
  output logic [BIT_WIDTH-1:0] mem_addr_out,
  output logic                 mem_we_out,
  output logic [BIT_WIDTH-1:0] mem_wdata_out,
  input  logic [BIT_WIDTH-1:0] mem_rdata_in,
  output logic                 busy_out
);

  arb_state_t            state;
  arb_owner_t            owner;
  arb_owner_t            grant;
  logic [WAIT_CNT_W-1:0] wait_cnt;
  logic                  we_r;
  logic [BIT_WIDTH-1:0]  req_addr;

  // The current owner doubles as the last-winner flag for round-robin ties.
  mem_arb_grant u_grant (
    .if_req     (if_req_in),
    .d_req      (d_req_in),
    .last_owner (owner),
    .grant      (grant)
  );

  assign req_addr = (grant == OWN_DATA) ? d_addr_in : if_addr_in;
  assign busy_out = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      owner         <= OWN_FETCH;
      wait_cnt      <= '0;
      we_r          <= 1'b0;
      mem_addr_out  <= '0;
      mem_we_out    <= 1'b0;
      mem_wdata_out <= '0;
      if_rdata_out  <= '0;
      d_rdata_out   <= '0;
      if_ack_out    <= 1'b0;
      d_ack_out     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if_ack_out <= 1'b0;
      d_ack_out  <= 1'b0;
      mem_we_out <= 1'b0;
      unique case (state)
        IDLE: begin
          if (if_req_in || d_req_in) begin
            owner        <= grant;
            mem_addr_out <= req_addr >> ADDR_SHIFT;
            we_r         <= (grant == OWN_DATA) && d_we_in;
            if (grant == OWN_DATA) mem_wdata_out <= d_wdata_in;
            wait_cnt     <= WAIT_CNT_W'(WAIT_STATES);
            // With no wait states the first ACCESS cycle is also the final one.
            mem_we_out   <= (grant == OWN_DATA) && d_we_in && (WAIT_STATES == 0);
            state        <= ACCESS;
          end
        end
        ACCESS: begin
          if (wait_cnt == '0) begin
            if (owner == OWN_DATA) begin
              d_rdata_out <= mem_rdata_in;
              d_ack_out   <= 1'b1;
            end else begin
              if_rdata_out <= mem_rdata_in;
              if_ack_out   <= 1'b1;
            end
            state <= RESP;
          end else begin
            wait_cnt   <= wait_cnt - 1'b1;
            mem_we_out <= we_r && (wait_cnt == WAIT_CNT_W'(1));
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // A requester must keep its request up for the whole access.
  property p_req_held;
    @(posedge clk) disable iff (reset)
      (state == ACCESS) |-> ((owner == OWN_DATA) ? d_req_in : if_req_in);
  endproperty
  a_req_held: assert property (p_req_held)
    else $error("mem_arbiter: request dropped before ack");

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences a single shared program/data memory between the instruction-fetch and data-access requesters of the multicycle MIPS datapath.
- Each access is registered, wait-stated and acknowledged.
- Sits between the control unit/datapath and the memory array, which has a combinational read port and a synchronous write port.
- The multicycle core can then use one unified memory without its FSM knowing the memory timing.

Parameters:
- BIT_WIDTH, 32, data and address width
- WAIT_STATES, 1, extra memory cycles per access (0..15)
- ADDR_SHIFT, 2, right shift from byte address to word index (2 = byte-addressed core)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- if_req_in  in  1  fetch request; held until if_ack_out
- if_addr_in  in  BIT_WIDTH  fetch byte address
- if_rdata_out  out  BIT_WIDTH  fetched word, valid while if_ack_out=1
- if_ack_out  out  1  one-cycle fetch completion pulse
- d_req_in  in  1  data request; held until d_ack_out
- d_we_in  in  1  1 = write, 0 = read
- d_addr_in  in  BIT_WIDTH  data byte address
- d_wdata_in  in  BIT_WIDTH  store data
- d_rdata_out  out  BIT_WIDTH  load data, valid while d_ack_out=1
- d_ack_out  out  1  one-cycle data completion pulse
- mem_addr_out  out  BIT_WIDTH  word index to memory
- mem_we_out  out  1  memory write enable
- mem_wdata_out  out  BIT_WIDTH  memory write data
- mem_rdata_in  in  BIT_WIDTH  memory combinational read data
- busy_out  out  1  high whenever state != IDLE

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - reset is asynchronous and active-high. While asserted: state=IDLE, wait counter=0, all outputs 0 (including the rdata registers and mem_addr_out), owner=FETCH.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If any request is pending, latch winner, address (>>ADDR_SHIFT), we and wdata into registers, load counter=WAIT_STATES, and go to ACCESS.
  - Otherwise stay in IDLE.
- ACCESS:
  - mem_addr_out, mem_we_out and mem_wdata_out are driven from the registers for exactly WAIT_STATES+1 cycles.
  - mem_we_out is asserted only in the final ACCESS cycle, so there is exactly one write per store.
  - On the final cycle, capture mem_rdata_in into the winner's rdata register and go to RESP.
- RESP:
  - Assert the winner's ack for exactly 1 cycle, then go to IDLE.
  - mem_we_out=0 and mem_addr_out holds its last value.
- Latency:
  - Request sampled at edge t gives ack high during cycle t+WAIT_STATES+2.
  - Minimum turnaround is WAIT_STATES+3 cycles per access, because IDLE always costs one cycle.
- Arbitration (default build): fixed priority, data wins over fetch when both are pending in IDLE. The losing request stays pending and is served next.
- Handshake:
  - Requester holds req, addr, we and wdata stable until ack.
  - If req is still high in the cycle after ack, it is a new request.
  - Dropping req before ack is a protocol violation. The access still completes, the ack still pulses, and simulation issues an assertion error.
- rdata_out holds its value after ack until that requester's next completion. Writes return rdata_out = the old memory word read in the final ACCESS cycle.
- if_ack_out and d_ack_out are never high in the same cycle.
- Address wrap: the word index is truncated to BIT_WIDTH with no range check; the memory decodes its own depth.
- Reset mid-access: abort immediately, no ack, no write if deasserted before the final ACCESS edge; the requester must re-issue.

Optional Feature:
- Macro MEM_ARB_ROUND_ROBIN_EN.
- Defined: on simultaneous requests in IDLE, the requester that did NOT win the last grant wins. A last-winner flag updates on each grant and resets to FETCH, so data wins the first tie.
- Undefined: fixed data-over-fetch priority as above. The flag is not implemented.

Decomposition:
- Package mem_arb_pkg:
  - typedef enum logic [1:0] {IDLE, ACCESS, RESP} arb_state_t
  - typedef enum logic {OWN_FETCH, OWN_DATA} arb_owner_t
  - localparam WAIT_CNT_W = 4
- One sub-module, mem_arb_grant: combinational winner select (fixed or round-robin), inputs if_req, d_req and last_owner, output grant owner.
- Counter and FSM stay in the top module.

Test Plan (WAIT_STATES=1, ADDR_SHIFT=2):
- Fetch only: if_req=1, if_addr=0x0000_0008, mem word[2]=0x2008_0005 -> mem_addr_out=2 for 2 cycles; if_ack pulses 3 cycles after the request edge with if_rdata=0x2008_0005; d_ack stays 0.
- Store then load:
  - d_we=1, d_addr=0x10, d_wdata=0xDEAD_BEEF -> mem_we high exactly 1 cycle with mem_addr=4.
  - Then a read of 0x10 -> d_rdata=0xDEAD_BEEF.
- Simultaneous if_req and d_req (read 0x4) in the same cycle:
  - Default build: d_ack first, then if_ack 4 cycles later; never both high together.
  - With MEM_ARB_ROUND_ROBIN_EN and both requests held high: grants alternate data, fetch, data.
- Back-to-back fetch with if_req held high across ack -> second access begins the cycle after RESP; busy_out drops for exactly 1 cycle.
- reset asserted during the final ACCESS cycle of a store (async, mid-cycle) -> outputs 0 immediately, no ack, memory word unchanged, state returns to IDLE.
- WAIT_STATES=0 build, fetch 0x0 -> ack 2 cycles after the request edge; mem_addr_out valid for 1 cycle.
